// File: rtl/and_sweep_checker.sv
// Exhaustive AND-gate sweep engine: drives every IN_W-bit vector to NUM_DUT gates and checks each against &vec.
// Optional AND_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module and_sweep_checker #(
    parameter int IN_W    = 2,
    parameter int NUM_DUT = 3,
    parameter int SETTLE  = 1,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [IN_W-1:0]    vec,
    input  logic [NUM_DUT-1:0] dut_o,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [IN_W-1:0]    fail_vec,
    output logic [NUM_DUT-1:0] fail_mask
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE);
    localparam logic [SET_W-1:0] SETTLE_ONE = SET_W'(1);

    // With no settle time the engine alternates straight between vectors in CHECK.
    localparam logic [1:0] RUN_STATE = (SETTLE == 0) ? CHECK : WAIT;

`ifdef AND_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    logic [1:0]         state_reg;
    logic [SET_W-1:0]   settle_reg;

    logic               expected;
    logic [NUM_DUT-1:0] mism;
    logic [NUM_DUT-1:0] bad;
    logic               any_bad;
    logic               vec_last;
    logic               err_sat;
    logic [CNT_W-1:0]   err_next;

    assign expected = &vec;
    assign vec_last = &vec;

    // Case inequality so an X/Z output from a gate is reported as a failure.
    generate
        for (genvar gi = 0; gi < NUM_DUT; gi++) begin : g_cmp
            assign mism[gi] = dut_o[gi] ^ expected;
            assign bad[gi]  = (dut_o[gi] !== expected);
        end
    endgenerate

    assign any_bad  = |bad;
    assign err_sat  = &err_cnt;
    assign err_next = (any_bad && !err_sat) ? err_cnt + CNT_W'(1) : err_cnt;

    assign busy = (state_reg == WAIT) || (state_reg == CHECK);
    assign done = (state_reg == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            settle_reg <= '0;
            vec        <= '0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_mask  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        vec        <= '0;
                        err_cnt    <= '0;
                        fail_vec   <= '0;
                        fail_mask  <= '0;
                        pass       <= 1'b0;
                        settle_reg <= SETTLE_LD;
                        state_reg  <= RUN_STATE;
                    end
                end

                WAIT: begin
                    if (settle_reg == SETTLE_ONE) begin
                        state_reg <= CHECK;
                    end
                    settle_reg <= settle_reg - SETTLE_ONE;
                end

                CHECK: begin
                    err_cnt <= err_next;
                    if (any_bad && (err_cnt == '0)) begin
                        fail_vec  <= vec;
                        fail_mask <= mism;
                    end
                    // pass is settled here so it is already valid during the done cycle.
                    if (vec_last || (STOP_ON_FAIL && any_bad)) begin
                        pass      <= (err_next == '0);
                        state_reg <= DONE;
                    end else begin
                        vec        <= vec + IN_W'(1);
                        settle_reg <= SETTLE_LD;
                        state_reg  <= RUN_STATE;
                    end
                end

                default: begin
                    vec       <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and_sweep_checker.sv
// Directed bench for and_sweep_checker: default instance (IN_W=2, SETTLE=1) and a 3-bit, SETTLE=0, CNT_W=2 instance.
module tb_and_sweep_checker;

`ifdef AND_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       start2;
    logic [2:0] fault1;
    logic [2:0] fault2;

    logic [1:0] vec;
    logic [2:0] dut_o;
    logic       busy, done, pass;
    logic [7:0] err_cnt;
    logic [1:0] fail_vec;
    logic [2:0] fail_mask;

    logic [2:0] vec2;
    logic [2:0] dut_o2;
    logic       busy2, done2, pass2;
    logic [1:0] err_cnt2;
    logic [2:0] fail_vec2;
    logic [2:0] fail_mask2;

    // Behavioural gates: correct AND with optional stuck-at-1 bits.
    assign dut_o  = {3{&vec}} | fault1;
    assign dut_o2 = {3{&vec2}} | fault2;

    and_sweep_checker #(.IN_W(2), .NUM_DUT(3), .SETTLE(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .start(start), .vec(vec), .dut_o(dut_o),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_vec(fail_vec), .fail_mask(fail_mask)
    );

    and_sweep_checker #(.IN_W(3), .NUM_DUT(3), .SETTLE(0), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .vec(vec2), .dut_o(dut_o2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
        .fail_vec(fail_vec2), .fail_mask(fail_mask2)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a sweep on u1 and follow it cycle by cycle; vec holds each value for 2 cycles.
    task automatic run1(input string name, input int lat, input int repulse_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, " pass cleared"}, 32'(pass), 32'd0);
        for (int k = 0; k < lat; k++) begin
            check($sformatf("%s vec k%0d", name, k), 32'(vec), 32'(k / 2));
            check($sformatf("%s busy k%0d", name, k), 32'(busy), 32'd1);
            check($sformatf("%s done k%0d", name, k), 32'(done), 32'd0);
            start = (k == repulse_at);
            tick();
        end
        start = 1'b0;
        check({name, " done"}, 32'(done), 32'd1);
        check({name, " busy off"}, 32'(busy), 32'd0);
        $display("%s: done after %0d cycles pass=%0d err_cnt=%0d fail_vec=%0d fail_mask=%b",
                 name, lat, pass, err_cnt, fail_vec, fail_mask);
    endtask

    task automatic run2(input string name, input int lat);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < lat; k++) begin
            check($sformatf("%s vec k%0d", name, k), 32'(vec2), 32'(k));
            check($sformatf("%s busy k%0d", name, k), 32'(busy2), 32'd1);
            check($sformatf("%s done k%0d", name, k), 32'(done2), 32'd0);
            tick();
        end
        check({name, " done"}, 32'(done2), 32'd1);
        check({name, " busy off"}, 32'(busy2), 32'd0);
        $display("%s: done after %0d cycles pass=%0d err_cnt=%0d fail_vec=%0d fail_mask=%b",
                 name, lat, pass2, err_cnt2, fail_vec2, fail_mask2);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        fault1 = 3'b000;
        fault2 = 3'b000;
        tick();
        tick();
        check("rst vec", 32'(vec), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst pass", 32'(pass), 32'd0);
        check("rst err_cnt", 32'(err_cnt), 32'd0);
        check("rst fail_vec", 32'(fail_vec), 32'd0);
        check("rst fail_mask", 32'(fail_mask), 32'd0);
        rst = 1'b0;
        tick();

        // Correct gates: full sweep, pass held afterwards.
        run1("good", 8, -1);
        check("good pass", 32'(pass), 32'd1);
        check("good err_cnt", 32'(err_cnt), 32'd0);
        check("good last vec", 32'(vec), 32'd3);
        tick();
        check("good done drop", 32'(done), 32'd0);
        check("good vec back", 32'(vec), 32'd0);
        tick();
        tick();
        check("good pass held", 32'(pass), 32'd1);

        // DUT1 stuck-at-1: fails on vectors 0,1,2.
        fault1 = 3'b010;
        run1("stuck1", STOP ? 2 : 8, -1);
        check("stuck1 err_cnt", 32'(err_cnt), STOP ? 32'd1 : 32'd3);
        check("stuck1 fail_vec", 32'(fail_vec), 32'd0);
        check("stuck1 fail_mask", 32'(fail_mask), 32'b010);
        check("stuck1 pass", 32'(pass), 32'd0);
        tick();
        fault1 = 3'b000;
        tick();

        // start re-pulsed mid-sweep must not disturb the timing.
        run1("repulse", 8, 3);
        check("repulse pass", 32'(pass), 32'd1);
        check("repulse err_cnt", 32'(err_cnt), 32'd0);
        tick();
        tick();
        check("repulse no restart", 32'(busy), 32'd0);

        // Asynchronous reset at vec=2.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("abort vec before", 32'(vec), 32'd2);
        #1 rst = 1'b1;
        #1;
        check("abort vec", 32'(vec), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort pass", 32'(pass), 32'd0);
        rst = 1'b0;
        tick();
        check("abort no done", 32'(done), 32'd0);
        run1("restart", 8, -1);
        check("restart pass", 32'(pass), 32'd1);
        tick();

        // 3-bit, SETTLE=0 instance.
        run2("w3 good", 8);
        check("w3 good pass", 32'(pass2), 32'd1);
        check("w3 good err_cnt", 32'(err_cnt2), 32'd0);
        tick();
        fault2 = 3'b111;
        run2("w3 stuck", STOP ? 1 : 8);
        check("w3 stuck err_cnt", 32'(err_cnt2), STOP ? 32'd1 : 32'd3);
        check("w3 stuck fail_vec", 32'(fail_vec2), 32'd0);
        check("w3 stuck fail_mask", 32'(fail_mask2), 32'b111);
        check("w3 stuck pass", 32'(pass2), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
